dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined core's load/store port. Accepts one read or
//  write request at a time, applies a configurable wait-state latency, performs
//  byte/half/word lane steering with sign/zero extension, and decodes a small MMIO
//  window (cycle counter, scratch register). Reports misaligned/out-of-range accesses.
// PARAMETERS
//  DEPTH_WORDS  1024         data RAM depth in 32-bit words (power of 2)
//  WAIT_CYCLES  2            extra cycles between request accept and mem_ready (0..15)
//  MMIO_BASE    32'hFFFF0000 base of MMIO window; +0 cycle counter (RO), +4 scratch (RW)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-low reset
//  mem_r      in   1   read request; held by initiator until mem_ready
//  mem_w      in   1   write request; held by initiator until mem_ready
//  Addr_in    in   32  byte address
//  Data_in    in   32  write data (low bits used for sb/sh)
//  DMType     in   3   access size/sign, encodings in shared defs
//  Data_out   out  32  read data, valid while mem_ready=1 and mem_err=0
//  mem_ready  out  1   one-cycle pulse: request completed
//  mem_err    out  1   one-cycle pulse with mem_ready: access rejected
// BEHAVIOUR
//  - Reset (reset==0 at edge): state=IDLE; Data_out=0, mem_ready=0, mem_err=0,
//    cycle counter=0, scratch=0. RAM contents NOT cleared. Mid-operation reset aborts
//    the request; no write is committed.
//  - FSM IDLE -> WAIT -> RESP -> IDLE.
//    IDLE: if exactly one of mem_r/mem_w is 1, latch Addr_in, Data_in, DMType, op;
//      go WAIT (WAIT_CYCLES>0, counter loaded WAIT_CYCLES-1) else RESP.
//      mem_r & mem_w both 1: no access, go RESP with err flagged.
//    WAIT: decrement counter; at 0 go RESP. Input changes ignored (latched copies used).
//    RESP: mem_ready=1 for exactly this cycle; write committed at the edge leaving RESP;
//      next state IDLE unconditionally (request still asserted is re-accepted in IDLE
//      only after the initiator sees ready: initiator must drop it the cycle after).
//  - Latency: accept edge to mem_ready = WAIT_CYCLES+1 cycles; throughput one access
//    per WAIT_CYCLES+2 cycles.
//  - DMType: 000 lw/sw, 001 lh/sh, 010 lhu, 011 lb/sb, 100 lbu; others -> err.
//  - Alignment: half requires addr[0]=0, word addr[1:0]=0; violation -> err.
//  - Range: RAM valid when addr < DEPTH_WORDS*4; MMIO valid at MMIO_BASE, MMIO_BASE+4
//    with word type only; anything else -> err.
//  - On err: no state changes, Data_out=0, mem_err=1 with mem_ready=1.
//  - Loads: select byte/half by addr[1:0], sign-extend (lb/lh) or zero-extend (lbu/lhu).
//  - Stores: merge only addressed bytes via per-byte write enables; other bytes kept.
//  - Cycle counter: +1 every cycle after reset, wraps 32'hFFFFFFFF -> 0; writes -> err.
//    Read returns value sampled on the RESP cycle.
//  - Scratch: RW word; write visible on the next read.
//  - Data_out/mem_err registered; both 0 outside RESP.
// STRUCTURE
//  - DMType encodings (dm_word, dm_halfword, dm_halfword_unsigned, dm_byte,
//    dm_byte_unsigned) and MMIO offsets go in ctrl_encode_def.v.
//  - Sub-module dm_lane_unit (combinational): addr[1:0], DMType, wdata, rword ->
//    byte-enable[3:0], merged write word, extended load data, misalign flag.
//  - RAM: single reg array DEPTH_WORDS x 32, one write port, one read port.
// TESTING
//  - sw 0x12345678 @0x10, lw @0x10, WAIT_CYCLES=2 -> ready 3 cycles after accept each,
//    read Data_out=0x12345678, err=0.
//  - sb 0xAB @0x13 over 0x12345678, then lb @0x13 -> 0xFFFFFFAB; lbu -> 0x000000AB;
//    lw @0x10 -> 0xAB345678.
//  - lh @0x11, sw @0x12 -> mem_err=1, mem_ready=1, Data_out=0, RAM word unchanged.
//  - mem_r=mem_w=1 and lw @DEPTH_WORDS*4 -> err pulses; sw to MMIO_BASE -> err.
//  - sw 0xCAFEF00D to MMIO_BASE+4, lw -> 0xCAFEF00D; two lw of MMIO_BASE N cycles
//    apart differ by N; force counter 0xFFFFFFFF -> next read wraps to small value.
//  - reset low during WAIT of sw 0x55 @0x20 -> ready/err stay 0, later lw @0x20 returns
//    prior value; FSM accepts next request immediately after reset high.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared definitions for the data-memory responder.
//   - dm_type_e   : DMType access size/sign encodings
//   - state_e     : responder FSM states
//   - op_e        : latched request kind
//   - MMIO offsets and a DMType validity helper
package dmem_responder_pkg;

    typedef enum logic [2:0] {
        DmWord             = 3'b000,
        DmHalfword         = 3'b001,
        DmHalfwordUnsigned = 3'b010,
        DmByte             = 3'b011,
        DmByteUnsigned     = 3'b100
    } dm_type_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpBoth
    } op_e;

    localparam logic [31:0] MmioCntOffset     = 32'h0000_0000;
    localparam logic [31:0] MmioScratchOffset = 32'h0000_0004;

    function automatic logic dm_type_valid(input logic [2:0] t);
        return t <= 3'(DmByteUnsigned);
    endfunction

endpackage

// File: rtl/dmem_responder_dm_lane_unit.sv
// dm_lane_unit: combinational byte-lane steering for loads and stores.
//   addr_lo_i  : byte offset within the word
//   dm_type_i  : DMType access size/sign
//   wdata_i    : store data (low bits used for sb/sh)
//   rword_i    : current RAM word at the addressed index
//   byte_en_o  : per-byte write enables for stores
//   wword_o    : rword_i with the addressed bytes replaced by store data
//   rdata_o    : selected and sign/zero-extended load data
//   misalign_o : half not 2-byte aligned or word not 4-byte aligned
module dm_lane_unit
    import dmem_responder_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  dm_type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wword_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [31:0] wrep;
    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    assign byte_sel = rword_i[{addr_lo_i, 3'b000} +: 8];

    always_comb begin
        byte_en_o  = 4'b0000;
        rdata_o    = 32'h0;
        misalign_o = 1'b0;
        wrep       = wdata_i;
        case (dm_type_i)
            DmWord: begin
                byte_en_o  = 4'b1111;
                misalign_o = (addr_lo_i != 2'b00);
                rdata_o    = rword_i;
            end
            DmHalfword, DmHalfwordUnsigned: begin
                byte_en_o  = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misalign_o = addr_lo_i[0];
                wrep       = {2{wdata_i[15:0]}};
                rdata_o    = (dm_type_i == DmHalfword) ? {{16{half_sel[15]}}, half_sel}
                                                       : {16'h0, half_sel};
            end
            DmByte, DmByteUnsigned: begin
                byte_en_o = 4'b0001 << addr_lo_i;
                wrep      = {4{wdata_i[7:0]}};
                rdata_o   = (dm_type_i == DmByte) ? {{24{byte_sel[7]}}, byte_sel}
                                                  : {24'h0, byte_sel};
            end
            default: ;
        endcase
    end

    // Store data is replicated across lanes, so the enable alone picks the target bytes.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wword_o[8*i +: 8] = byte_en_o[i] ? wrep[8*i +: 8] : rword_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding load/store responder with wait states,
// lane steering and a two-register MMIO window (cycle counter RO, scratch RW).
//   clk, reset           : clock, synchronous active-low reset
//   mem_r, mem_w         : read/write request, held until mem_ready
//   Addr_in, Data_in     : byte address and store data
//   DMType               : access size/sign
//   Data_out             : load data, valid with mem_ready && !mem_err
//   mem_ready, mem_err   : one-cycle completion pulse, error flag with it
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_r,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        mem_ready,
    output logic        mem_err
);

    localparam int unsigned IdxW     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RamBytes = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WaitInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  dm_type_q, dm_type_d;
    op_e         op_q, op_d;
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] scratch_q;
    logic [31:0] data_out_q, data_out_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic [31:0] ram [DEPTH_WORDS];

    // In IDLE the request is decoded straight from the inputs so a zero-wait access
    // can complete without first passing through the latches.
    logic [31:0] cur_addr, cur_wdata;
    logic [2:0]  cur_type;
    op_e         cur_op, in_op;
    logic [IdxW-1:0] word_idx;
    logic [31:0] rword, lane_wword, lane_rdata, load_data;
    logic [3:0]  lane_be;
    logic        misalign, in_ram, is_cnt, is_scr, req_err, ram_we, scr_we;

    assign in_op     = (mem_r && mem_w) ? OpBoth : (mem_w ? OpWrite : OpRead);
    assign cur_addr  = (state_q == StIdle) ? Addr_in : addr_q;
    assign cur_wdata = (state_q == StIdle) ? Data_in : wdata_q;
    assign cur_type  = (state_q == StIdle) ? DMType  : dm_type_q;
    assign cur_op    = (state_q == StIdle) ? in_op   : op_q;

    assign word_idx = cur_addr[IdxW+1:2];
    assign rword    = ram[word_idx];

    dm_lane_unit u_lane (
        .addr_lo_i  (cur_addr[1:0]),
        .dm_type_i  (cur_type),
        .wdata_i    (cur_wdata),
        .rword_i    (rword),
        .byte_en_o  (lane_be),
        .wword_o    (lane_wword),
        .rdata_o    (lane_rdata),
        .misalign_o (misalign)
    );

    assign in_ram = (cur_addr < RamBytes);
    assign is_cnt = (cur_addr == MMIO_BASE + MmioCntOffset);
    assign is_scr = (cur_addr == MMIO_BASE + MmioScratchOffset);

    assign req_err = (cur_op == OpBoth) || !dm_type_valid(cur_type) || misalign ||
                     !(in_ram || ((is_cnt || is_scr) && cur_type == DmWord)) ||
                     (cur_op == OpWrite && is_cnt);

    assign cyc_cnt_d = cyc_cnt_q + 32'd1;
    // Counter reads report the value held during the RESP cycle, i.e. the next value.
    assign load_data = is_cnt ? cyc_cnt_d : (is_scr ? scratch_q : lane_rdata);

    // Commit happens on the edge leaving RESP; err_q is the flag shown in that cycle.
    assign ram_we = (state_q == StResp) && !err_q && (op_q == OpWrite) && in_ram;
    assign scr_we = (state_q == StResp) && !err_q && (op_q == OpWrite) && is_scr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            dm_type_q  <= 3'b000;
            op_q       <= OpRead;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dm_type_q  <= dm_type_d;
            op_q       <= op_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dm_type_d  = dm_type_q;
        op_d       = op_q;
        unique case (state_q)
            StIdle: begin
                if (mem_r || mem_w) begin
                    addr_d     = Addr_in;
                    wdata_d    = Data_in;
                    dm_type_d  = DMType;
                    op_d       = in_op;
                    wait_cnt_d = WaitInit;
                    if (mem_r && mem_w) begin
                        state_d = StResp;
                    end else if (WAIT_CYCLES > 0) begin
                        state_d = StWait;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ready_d    = (state_d == StResp);
        err_d      = ready_d && req_err;
        data_out_d = (ready_d && !req_err && cur_op == OpRead) ? load_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_cnt_q  <= 32'h0;
            scratch_q  <= 32'h0;
            data_out_q <= 32'h0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cyc_cnt_q  <= cyc_cnt_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            if (scr_we) begin
                scratch_q <= wdata_q;
            end
        end
    end

    // RAM is deliberately not reset; a reset in RESP still suppresses the commit.
    always_ff @(posedge clk) begin
        if (reset && ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_be[i]) begin
                    ram[word_idx][8*i +: 8] <= lane_wword[8*i +: 8];
                end
            end
        end
    end

    assign Data_out  = data_out_q;
    assign mem_ready = ready_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WAITC = 2;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;
    localparam logic [31:0] RAMB  = 32'(DEPTH * 4);

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_r = 1'b0;
    logic        mem_w = 1'b0;
    logic [31:0] Addr_in = 32'h0;
    logic [31:0] Data_in = 32'h0;
    logic [2:0]  DMType = 3'b000;
    logic [31:0] Data_out;
    logic        mem_ready;
    logic        mem_err;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .MMIO_BASE   (MMIO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .Addr_in   (Addr_in),
        .Data_in   (Data_in),
        .DMType    (DMType),
        .Data_out  (Data_out),
        .mem_ready (mem_ready),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // Reference state: byte-addressed RAM, scratch word, cycles since reset.
    logic [7:0]  mem_m [RAMB];
    logic [31:0] scratch_m;
    logic [31:0] tb_cyc;
    logic [31:0] cyc_ofs;
    int          n_checks = 0;
    int          n_pass = 0;

    always @(posedge clk) begin
        if (!reset) tb_cyc <= 32'h0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int acc_size(input logic [2:0] t);
        case (t)
            3'd0:       return 4;
            3'd1, 3'd2: return 2;
            3'd3, 3'd4: return 1;
            default:    return 0;
        endcase
    endfunction

    function automatic logic model_err(input logic r, input logic w, input logic [31:0] a,
                                       input logic [2:0] t);
        int s;
        s = acc_size(t);
        if (r && w) return 1'b1;
        if (s == 0) return 1'b1;
        if (s == 4 && a[1:0] != 2'b00) return 1'b1;
        if (s == 2 && a[0]) return 1'b1;
        if (a < RAMB) return 1'b0;
        if (a == MMIO && t == 3'd0 && !w) return 1'b0;
        if (a == MMIO + 32'd4 && t == 3'd0) return 1'b0;
        return 1'b1;
    endfunction

    // Runs one handshake starting at a negedge; ends at the negedge after the pulse.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] t, output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        int          s;
        bit          seen;
        exp_err = model_err(r, w, a, t);
        exp_lat = (r && w) ? 1 : int'(WAITC) + 1;
        s       = acc_size(t);
        mem_r = r; mem_w = w; Addr_in = a; Data_in = d; DMType = t;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = mem_ready;
        end
        check("ready_seen", 32'(seen), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("err", 32'(mem_err), 32'(exp_err));
        if (exp_err) begin
            check("err_data", Data_out, 32'h0);
        end else if (r) begin
            if (a == MMIO) begin
                exp_data = tb_cyc + cyc_ofs;
            end else if (a == MMIO + 32'd4) begin
                exp_data = scratch_m;
            end else begin
                exp_data = 32'h0;
                for (int i = 0; i < s; i++) exp_data |= 32'(mem_m[a + 32'(i)]) << (8 * i);
                if (t == 3'd1 && exp_data[15]) exp_data |= 32'hFFFF_0000;
                if (t == 3'd3 && exp_data[7])  exp_data |= 32'hFFFF_FF00;
            end
            check("rdata", Data_out, exp_data);
        end else begin
            if (a < RAMB) begin
                for (int i = 0; i < s; i++) mem_m[a + 32'(i)] = d[8*i +: 8];
            end else begin
                scratch_m = d;
            end
        end
        rd = Data_out;
        mem_r = 1'b0;
        mem_w = 1'b0;
        @(negedge clk);
        check("pulse_ready", 32'(mem_ready), 32'd0);
        check("pulse_data", Data_out, 32'h0);
    endtask

    logic [31:0] rd, c1, c2;
    int          k, sel;
    logic [31:0] ra;

    initial begin
        cyc_ofs   = 32'h0;
        scratch_m = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(mem_ready), 32'd0);
        check("rst_err", 32'(mem_err), 32'd0);
        check("rst_data", Data_out, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) access(1'b0, 1'b1, 32'(i * 4), $urandom, 3'd0, rd);

        access(1'b0, 1'b1, 32'h10, 32'h1234_5678, 3'd0, rd);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0, rd);
        check("lw_10", rd, 32'h1234_5678);
        access(1'b0, 1'b1, 32'h13, 32'h0000_00AB, 3'd3, rd);
        access(1'b1, 1'b0, 32'h13, 32'h0, 3'd3, rd);
        check("lb_13", rd, 32'hFFFF_FFAB);
        access(1'b1, 1'b0, 32'h13, 32'h0, 3'd4, rd);
        check("lbu_13", rd, 32'h0000_00AB);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0, rd);
        check("lw_merged", rd, 32'hAB34_5678);

        access(1'b1, 1'b0, 32'h11, 32'h0, 3'd1, rd);
        access(1'b0, 1'b1, 32'h12, 32'hDEAD_BEEF, 3'd0, rd);
        access(1'b1, 1'b0, 32'h10, 32'h0, 3'd0, rd);
        check("lw_unchanged", rd, 32'hAB34_5678);

        access(1'b1, 1'b1, 32'h10, 32'h0, 3'd0, rd);
        access(1'b1, 1'b0, RAMB, 32'h0, 3'd0, rd);
        access(1'b0, 1'b1, MMIO, 32'h1, 3'd0, rd);
        access(1'b0, 1'b1, RAMB - 32'd4, 32'h0BAD_CAFE, 3'd0, rd);
        access(1'b1, 1'b0, RAMB - 32'd4, 32'h0, 3'd0, rd);
        check("lw_top", rd, 32'h0BAD_CAFE);

        access(1'b0, 1'b1, MMIO + 32'd4, 32'hCAFE_F00D, 3'd0, rd);
        access(1'b1, 1'b0, MMIO + 32'd4, 32'h0, 3'd0, rd);
        check("scratch", rd, 32'hCAFE_F00D);

        access(1'b1, 1'b0, MMIO, 32'h0, 3'd0, c1);
        repeat (7) @(negedge clk);
        access(1'b1, 1'b0, MMIO, 32'h0, 3'd0, c2);
        check("cnt_delta", c2 - c1, 32'(8 + WAITC + 1));

        force dut.cyc_cnt_q = 32'hFFFF_FFFF;
        cyc_ofs = 32'hFFFF_FFFF - tb_cyc;
        #1 release dut.cyc_cnt_q;
        access(1'b1, 1'b0, MMIO, 32'h0, 3'd0, rd);
        check("cnt_wrapped", 32'(rd < 32'd16), 32'd1);

        // Reset in the middle of a store: nothing committed, no pulse, prompt restart.
        mem_w = 1'b1; Addr_in = 32'h20; Data_in = 32'h55; DMType = 3'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_w = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort_ready", 32'(mem_ready), 32'd0);
        check("abort_err", 32'(mem_err), 32'd0);
        reset     = 1'b1;
        cyc_ofs   = 32'h0;
        scratch_m = 32'h0;
        access(1'b1, 1'b0, 32'h20, 32'h0, 3'd0, rd);
        access(1'b1, 1'b0, MMIO + 32'd4, 32'h0, 3'd0, rd);

        for (int n = 0; n < 300; n++) begin
            k   = int'($urandom_range(0, 9));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      ra = RAMB + $urandom_range(0, 15);
            else if (sel == 1) ra = MMIO + 32'(4 * $urandom_range(0, 2));
            else               ra = $urandom_range(0, 127);
            access(k == 0 || k < 5, k == 0 || k >= 5, ra, $urandom,
                   3'($urandom_range(0, 7)), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
